// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding and
// the default bus address.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        ACK_DEV,
        SUB,
        ACK_SUB,
        WR,
        ACK_WR,
        RD,
        MACK
    } i2c_state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h60;
    localparam logic [2:0] FIRST_BIT        = 3'd7;

endpackage

// File: rtl/i2c_target_if.sv
// Line-level bundle between the SCL/SDA synchronizer and the protocol FSM:
// raw pin levels in, clean edge and START/STOP strobes out.
interface i2c_target_if;

    logic scl_raw;
    logic sda_raw;
    logic scl_rise;
    logic scl_fall;
    logic sda_bit;
    logic start_det;
    logic stop_det;

    modport master (
        input  scl_raw, sda_raw,
        output scl_rise, scl_fall, sda_bit, start_det, stop_det
    );

    modport slave (
        output scl_raw, sda_raw,
        input  scl_rise, scl_fall, sda_bit, start_det, stop_det
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives single-clk strobes
// for SCL edges and bus START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    i2c_target_if.master  line
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_now;
    logic                   sda_now;

    // Idle bus level is high, so every stage resets to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync[0] <= line.scl_raw;
            sda_sync[0] <= line.sda_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_hist <= scl_now;
            sda_hist <= sda_now;
        end
    end

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    assign line.scl_rise  = scl_now & ~scl_hist;
    assign line.scl_fall  = ~scl_now & scl_hist;
    assign line.sda_bit   = sda_now;
    assign line.start_det = scl_now & scl_hist & sda_hist & ~sda_now;
    assign line.stop_det  = scl_now & scl_hist & ~sda_hist & sda_now;

endmodule

// File: rtl/i2c_target.sv
// I2C register-bank target: address match, sub-address pointer with
// auto-increment, byte writes to the bank and streamed reads from it.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    i2c_target_if line ();

    assign line.scl_raw = SCL;
    assign line.sda_raw = SDA;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .line (line)
    );

    i2c_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] reg_addr_n, reg_wdata_n;
    logic [7:0] byte_in;
    logic       sda_oe, sda_oe_n;
    logic       ack_on, ack_on_n;
    logic       rw, rw_n;
    logic       got_ack, got_ack_n;
    logic       we_pend, we_pend_n;
    logic       busy_n;
    logic       re_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            sda_oe    <= 1'b0;
            ack_on    <= 1'b0;
            rw        <= 1'b0;
            got_ack   <= 1'b0;
            we_pend   <= 1'b0;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            sda_oe    <= sda_oe_n;
            ack_on    <= ack_on_n;
            rw        <= rw_n;
            got_ack   <= got_ack_n;
            we_pend   <= we_pend_n;
            reg_we    <= we_pend;
            busy      <= busy_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
        end
    end

    assign byte_in = {shift[6:0], line.sda_bit};

    // Receive bits are taken on SCL rise; all SDA drive changes happen on SCL fall.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        sda_oe_n    = sda_oe;
        ack_on_n    = ack_on;
        rw_n        = rw;
        got_ack_n   = got_ack;
        we_pend_n   = 1'b0;
        busy_n      = busy;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        re_pulse    = 1'b0;

        if (line.stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            ack_on_n = 1'b0;
            busy_n   = 1'b0;
        end else if (line.start_det) begin
            state_n   = DEV;
            bit_cnt_n = FIRST_BIT;
            sda_oe_n  = 1'b0;
            ack_on_n  = 1'b0;
        end else begin
            case (state)
                DEV, SUB, WR: begin
                    if (line.scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            if (state == DEV) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_n = ACK_DEV;
                                    rw_n    = byte_in[0];
                                    busy_n  = 1'b1;
                                end else begin
                                    state_n = IDLE;
                                    busy_n  = 1'b0;
                                end
                            end else if (state == SUB) begin
                                reg_addr_n = byte_in;
                                state_n    = ACK_SUB;
                            end else begin
                                reg_wdata_n = byte_in;
                                we_pend_n   = 1'b1;
                                state_n     = ACK_WR;
                            end
                        end
                    end
                end
                // First fall pulls the ACK low, second fall ends the ACK slot.
                ACK_DEV, ACK_SUB, ACK_WR: begin
                    if (line.scl_fall) begin
                        if (!ack_on) begin
                            sda_oe_n = 1'b1;
                            ack_on_n = 1'b1;
                        end else begin
                            ack_on_n  = 1'b0;
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = FIRST_BIT;
                            if (state == ACK_DEV) begin
                                if (rw) begin
                                    re_pulse = 1'b1;
                                    shift_n  = reg_rdata;
                                    sda_oe_n = ~reg_rdata[7];
                                    state_n  = RD;
                                end else begin
                                    state_n = SUB;
                                end
                            end else if (state == ACK_SUB) begin
                                state_n = WR;
                            end else begin
                                reg_addr_n = reg_addr + 8'd1;
                                state_n    = WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (line.scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n  = 1'b0;
                            got_ack_n = 1'b0;
                            state_n   = MACK;
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                            shift_n   = {shift[6:0], 1'b0};
                            sda_oe_n  = ~shift[6];
                        end
                    end
                end
                // The pointer advances on the master's ACK so reg_rdata is ready by the fall.
                MACK: begin
                    if (line.scl_rise) begin
                        if (!line.sda_bit) begin
                            got_ack_n  = 1'b1;
                            reg_addr_n = reg_addr + 8'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (line.scl_fall && got_ack) begin
                        got_ack_n = 1'b0;
                        re_pulse  = 1'b1;
                        shift_n   = reg_rdata;
                        sda_oe_n  = ~reg_rdata[7];
                        bit_cnt_n = FIRST_BIT;
                        state_n   = RD;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    assign reg_re = re_pulse & ~rst;
    assign SDA    = sda_oe ? 1'b0 : 1'bz;

endmodule
